// File: rtl/osd_pkg.sv
// Shared constants, opcodes and types for the OSD window generator.
package osd_pkg;

  localparam int unsigned OSD_COLS  = 256;
  localparam int unsigned OSD_ROWS  = 8;
  localparam int unsigned OSD_LINES = 64;
  localparam int unsigned PIX_CLKS  = 4;
  localparam int unsigned BUF_AW    = 11;

  localparam logic [7:0] CMD_ADDR = 8'b0010_0000;
  localparam logic [7:0] CMD_EN   = 8'b0100_0000;
  localparam logic [7:0] CMD_CLR  = 8'h80;

  typedef enum logic [0:0] {StIdle, StClear} clr_state_e;

  typedef enum logic [1:0] {OpNone, OpAddr, OpEn, OpClr} host_op_e;

  // Low bits of CMD_ADDR/CMD_EN carry operands, so only the opcode field is matched.
  function automatic host_op_e decode_cmd(input logic [7:0] b);
    if (b[7:3] == CMD_ADDR[7:3]) return OpAddr;
    if (b[7:1] == CMD_EN[7:1]) return OpEn;
    if (b == CMD_CLR) return OpClr;
    return OpNone;
  endfunction

endpackage

// File: rtl/osd_ram.sv
// 2048x8 simple dual-port bitmap RAM; registered read returns the old byte on collision.
module osd_ram
  import osd_pkg::*;
(
  input  logic              clk28m,
  input  logic              we_i,
  input  logic [BUF_AW-1:0] waddr_i,
  input  logic [7:0]        wdata_i,
  input  logic [BUF_AW-1:0] raddr_i,
  output logic [7:0]        rdata_o
);

  logic [7:0] mem [2**BUF_AW];
  logic [7:0] rdata_q;

  always_ff @(posedge clk28m) begin
    if (we_i) mem[waddr_i] <= wdata_i;
    rdata_q <= mem[raddr_i];
  end

  assign rdata_o = rdata_q;

endmodule

// File: rtl/osd_overlay.sv
// OSD window generator: host bitmap port, raster tracking from native syncs, and a
// two-stage pixel pipeline (RAM read, output register).
module osd_overlay
  import osd_pkg::*;
#(
  parameter int unsigned HSTART = 400,
  parameter int unsigned VSTART = 80
) (
  input  logic       clk28m,
  input  logic       _reset,
  input  logic       _hsyncin,
  input  logic       _vsyncin,
  input  logic       host_strobe,
  input  logic       host_cmd,
  input  logic [7:0] host_data,
  output logic       busy,
  output logic       osdblank,
  output logic       osdpixel
);

  localparam logic [11:0] H_LO = 12'(HSTART);
  localparam logic [11:0] H_HI = 12'(HSTART + OSD_COLS * PIX_CLKS);
  localparam logic [10:0] V_LO = 11'(VSTART);
  localparam logic [10:0] V_HI = 11'(VSTART + OSD_LINES);

  // Sync sampling and falling-edge detection.
  logic hs_s_q, hs_d_q, vs_s_q, vs_d_q;
  logic hs_fall, vs_fall;

  always_ff @(posedge clk28m or negedge _reset) begin
    if (!_reset) begin
      hs_s_q <= 1'b0;
      hs_d_q <= 1'b0;
      vs_s_q <= 1'b0;
      vs_d_q <= 1'b0;
    end else begin
      hs_s_q <= _hsyncin;
      hs_d_q <= hs_s_q;
      vs_s_q <= _vsyncin;
      vs_d_q <= vs_s_q;
    end
  end

  assign hs_fall = hs_d_q & ~hs_s_q;
  assign vs_fall = vs_d_q & ~vs_s_q;

  // Raster counters saturate so missing syncs leave the window off.
  logic [10:0] hcnt_q;
  logic [9:0]  vcnt_q;
  logic        enable_q, pend_q, pend_d;

  always_ff @(posedge clk28m or negedge _reset) begin
    if (!_reset) begin
      hcnt_q   <= 11'h7FF;
      vcnt_q   <= 10'h3FF;
      enable_q <= 1'b0;
    end else begin
      if (hs_fall) hcnt_q <= '0;
      else if (hcnt_q != 11'h7FF) hcnt_q <= hcnt_q + 11'd1;

      if (vs_fall) vcnt_q <= '0;
      else if (hs_fall && vcnt_q != 10'h3FF) vcnt_q <= vcnt_q + 10'd1;

      if (vs_fall) enable_q <= pend_q;
    end
  end

  // Host command decoder and clear sequencer.
  clr_state_e        state_q, state_d;
  logic [BUF_AW-1:0] waddr_q, waddr_d;
  logic              ram_we;
  logic [7:0]        ram_wdata;
  host_op_e          op;

  assign op = decode_cmd(host_data);

  always_comb begin
    state_d   = state_q;
    waddr_d   = waddr_q;
    pend_d    = pend_q;
    ram_we    = 1'b0;
    ram_wdata = host_data;
    unique case (state_q)
      StIdle: begin
        if (host_strobe) begin
          if (host_cmd) begin
            unique case (op)
              OpAddr: waddr_d = {host_data[2:0], 8'h00};
              OpEn:   pend_d  = host_data[0];
              OpClr: begin
                state_d = StClear;
                waddr_d = '0;
              end
              OpNone: ;
            endcase
          end else begin
            ram_we  = 1'b1;
            waddr_d = waddr_q + 11'd1;
          end
        end
      end
      StClear: begin
        // The address wraps back to 0 on the final write.
        ram_we    = 1'b1;
        ram_wdata = '0;
        waddr_d   = waddr_q + 11'd1;
        if (waddr_q == '1) state_d = StIdle;
      end
    endcase
  end

  always_ff @(posedge clk28m or negedge _reset) begin
    if (!_reset) begin
      state_q <= StIdle;
      waddr_q <= '0;
      pend_q  <= 1'b0;
    end else begin
      state_q <= state_d;
      waddr_q <= waddr_d;
      pend_q  <= pend_d;
    end
  end

  assign busy = (state_q == StClear);

  // Window decode: 4 clocks per OSD pixel, 8 lines per text row.
  logic       in_win;
  logic [7:0] col;
  logic [5:0] dy;
  logic [7:0] rdata;

  assign col    = 8'((hcnt_q - 11'(HSTART)) >> 2);
  assign dy     = 6'(vcnt_q - 10'(VSTART));
  assign in_win = enable_q
                  && ({1'b0, hcnt_q} >= H_LO) && ({1'b0, hcnt_q} < H_HI)
                  && ({1'b0, vcnt_q} >= V_LO) && ({1'b0, vcnt_q} < V_HI);

  osd_ram u_ram (
    .clk28m  (clk28m),
    .we_i    (ram_we),
    .waddr_i (waddr_q),
    .wdata_i (ram_wdata),
    .raddr_i ({dy[5:3], col}),
    .rdata_o (rdata)
  );

  logic       win_q, blank_q, pix_q;
  logic [2:0] bit_q;

  always_ff @(posedge clk28m or negedge _reset) begin
    if (!_reset) begin
      win_q   <= 1'b0;
      bit_q   <= '0;
      blank_q <= 1'b0;
      pix_q   <= 1'b0;
    end else begin
      win_q   <= in_win;
      bit_q   <= dy[2:0];
      blank_q <= win_q;
      pix_q   <= win_q & rdata[bit_q];
    end
  end

  assign osdblank = blank_q;
  assign osdpixel = pix_q;

endmodule

// File: tb/tb_osd_overlay.sv
// Directed bench for osd_overlay with a per-cycle pixel scoreboard.
module tb_osd_overlay;

  localparam int HS = 16;
  localparam int VS = 4;
  localparam int LS = HS + 3 + 48;
  localparam int LL = HS + 3 + 1024 + 8;

  logic       clk28m = 1'b0;
  logic       _reset = 1'b0;
  logic       _hsyncin = 1'b1;
  logic       _vsyncin = 1'b1;
  logic       host_strobe = 1'b0;
  logic       host_cmd = 1'b0;
  logic [7:0] host_data = 8'h00;
  logic       busy, osdblank, osdpixel;

  always #5 clk28m = ~clk28m;

  osd_overlay #(
    .HSTART (HS),
    .VSTART (VS)
  ) dut (
    .clk28m      (clk28m),
    ._reset      (_reset),
    ._hsyncin    (_hsyncin),
    ._vsyncin    (_vsyncin),
    .host_strobe (host_strobe),
    .host_cmd    (host_cmd),
    .host_data   (host_data),
    .busy        (busy),
    .osdblank    (osdblank),
    .osdpixel    (osdpixel)
  );

  typedef struct {
    logic [1:0] v;
    int         ln;
    int         p;
  } exp_t;

  exp_t       sb[$];
  exp_t       e_chk;
  int         n_vec = 0;
  int         n_err = 0;
  logic [7:0] bm [2048];
  int         wa = 0;
  bit         pend_m = 1'b0;
  bit         en_m = 1'b0;
  int         ln = 1023;
  int         cnt;

  always @(negedge clk28m) begin
    if (sb.size() != 0) begin
      e_chk = sb.pop_front();
      n_vec++;
      assert ({osdblank, osdpixel} === e_chk.v) else begin
        n_err++;
        $error("FAIL pix ln=%0d p=%0d observed blank/pix=%b expected=%b",
               e_chk.ln, e_chk.p, {osdblank, osdpixel}, e_chk.v);
      end
    end
  end

  initial begin
    #5ms;
    $display("FAIL watchdog expired");
    $fatal(1);
  end

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_vec++;
    assert (obs === exp) else begin
      n_err++;
      $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  task automatic tick();
    @(posedge clk28m);
    #1;
  endtask

  function automatic logic [1:0] model_pix(input int p);
    int         dx, dy;
    logic [7:0] b;
    if (!en_m || ln < VS || ln >= VS + 64 || p < HS || p >= HS + 1024) return 2'b00;
    dx = p - HS;
    dy = ln - VS;
    b  = bm[(dy / 8) * 256 + dx / 4];
    return {1'b1, b[dy % 8]};
  endfunction

  task automatic reset_model();
    en_m   = 1'b0;
    pend_m = 1'b0;
    wa     = 0;
    ln     = 1023;
  endtask

  task automatic host(input bit c, input logic [7:0] d);
    host_strobe = 1'b1;
    host_cmd    = c;
    host_data   = d;
    tick();
    host_strobe = 1'b0;
    if (c) begin
      if (d[7:3] == 5'b00100) wa = int'(d[2:0]) * 256;
      else if (d[7:1] == 7'b0100000) pend_m = d[0];
      else if (d == 8'h80) begin
        for (int i = 0; i < 2048; i++) bm[i] = 8'h00;
        wa = 0;
      end
    end else begin
      bm[wa] = d;
      wa = (wa + 1) % 2048;
    end
  endtask

  // One raster line of len clocks after the hsync sample edge; rst_at pulses _reset.
  task automatic line(input int len, input bit vs, input int rst_at);
    exp_t e;
    _hsyncin = 1'b0;
    if (vs) _vsyncin = 1'b0;
    tick();
    if (vs) begin
      ln   = 0;
      en_m = pend_m;
    end else if (ln < 1023) ln++;
    for (int k = 1; k <= len; k++) begin
      tick();
      if (k == 4) begin
        _hsyncin = 1'b1;
        _vsyncin = 1'b1;
      end
      if (k == rst_at) begin
        #2 _reset = 1'b0;
        #1;
        chk("rst_busy", busy, 0);
        chk("rst_blank", osdblank, 0);
        chk("rst_pix", osdpixel, 0);
        reset_model();
      end
      if (k >= 3) begin
        e.v  = model_pix(k - 3);
        e.ln = ln;
        e.p  = k - 3;
        sb.push_back(e);
      end
      if (k == rst_at) #2 _reset = 1'b1;
    end
  endtask

  initial begin
    repeat (3) tick();
    chk("reset_busy", busy, 0);
    chk("reset_blank", osdblank, 0);
    chk("reset_pix", osdpixel, 0);
    _reset = 1'b1;
    repeat (4) tick();
    chk("idle_busy", busy, 0);
    chk("idle_blank", osdblank, 0);

    // Fill from 0 with 2049 bytes; the last one lands on address 0.
    host(1'b1, 8'h20);
    for (int i = 0; i < 2049; i++) host(1'b0, 8'(i * 37 + 5));
    host(1'b1, 8'h22);
    host(1'b0, 8'h01);
    host(1'b0, 8'hFF);
    host(1'b1, 8'h41);
    line(LS, 1'b0, 0);
    line(LS, 1'b0, 0);

    // Frame A: enable applies at vsync; disable mid-frame must not tear.
    line(LS, 1'b1, 0);
    for (int l = 1; l <= VS + 64; l++) begin
      line((l == VS) ? LL : LS, 1'b0, 0);
      if (l == VS + 30) host(1'b1, 8'h40);
    end

    // Frame B: window gone.
    for (int l = 0; l <= VS + 2; l++) line((l == VS) ? LL : LS, l == 0, 0);

    // Clear with a dropped data strobe part-way through.
    host(1'b1, 8'h41);
    host(1'b1, 8'h80);
    chk("busy_rise", busy, 1);
    cnt = 0;
    while (busy === 1'b1 && cnt < 4000) begin
      cnt++;
      if (cnt == 100) begin
        host_strobe = 1'b1;
        host_cmd    = 1'b0;
        host_data   = 8'hA5;
      end
      tick();
      host_strobe = 1'b0;
    end
    chk("busy_len", cnt, 2048);
    host(1'b0, 8'hFF);

    // Frame C: cleared bitmap plus one byte at 0; reset hits inside the window.
    for (int l = 0; l <= VS; l++)
      line((l == VS) ? LL : LS, l == 0, (l == VS) ? HS + 3 + 100 : 0);
    for (int l = 0; l <= VS + 2; l++) line((l == VS) ? LL : LS, l == 0, 0);

    // Reset during a clear.
    host(1'b1, 8'h80);
    repeat (50) tick();
    chk("clr_busy", busy, 1);
    #2 _reset = 1'b0;
    #1;
    chk("clr_rst_busy", busy, 0);
    chk("clr_rst_blank", osdblank, 0);
    chk("clr_rst_pix", osdpixel, 0);
    reset_model();
    #2 _reset = 1'b1;
    repeat (5) tick();
    chk("post_rst_busy", busy, 0);
    line(LS, 1'b1, 0);
    for (int l = 1; l <= VS + 1; l++) line((l == VS) ? LL : LS, 1'b0, 0);

    repeat (2) tick();
    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
    $finish;
  end

endmodule

// File: doc/osd_overlay.md
# osd_overlay

On-screen-display window generator sitting directly upstream of the scandoubler/OSD mixer. It holds a 256x64-pixel monochrome bitmap written by the host controller through a byte command port. It tracks the Amiga raster from the native `_hsyncin` and `_vsyncin` and drives `osdblank` (window active) and `osdpixel` (text pixel), pixel-aligned to the native video the mixer receives.

## Interface
- `HSTART`, default 400: clk28m cycles from line start to first window pixel.
- `VSTART`, default 80: raster lines from frame start to first window line.
- `clk28m`  in  1  28 MHz system clock; all logic on its rising edge.
- `_reset`  in  1  asynchronous, active-low reset.
- `_hsyncin`  in  1  native horizontal sync, active low.
- `_vsyncin`  in  1  native vertical sync, active low.
- `host_strobe`  in  1  one-cycle pulse; accepts `host_cmd`/`host_data`.
- `host_cmd`  in  1  1 = command byte, 0 = bitmap data byte.
- `host_data`  in  8  command or data byte.
- `busy`  out  1  clear sequence in progress; strobes are dropped.
- `osdblank`  out  1  OSD window active on the current pixel.
- `osdpixel`  out  1  OSD foreground pixel; only meaningful while `osdblank` is high.

## Operation
- Bitmap: 2048 bytes, address = {row[2:0], col[7:0]}. Each byte is an 8-pixel vertical column of one text row. Bit 0 is the top pixel.
- Commands, accepted when `host_strobe & host_cmd & ~busy`:
  - `8'b0010_0rrr`: write address <= {rrr, 8'h00}.
  - `8'b0100_000e`: pending_enable <= e.
  - `8'h80`: start clear. Writes 0 to all 2048 bytes, one per cycle, from address 0. `busy` is high for exactly 2048 cycles. The write address is left at 0 when the clear ends.
  - Any other command byte is ignored.
- Data: `host_strobe & ~host_cmd & ~busy` writes `host_data` at the write address, then increments the address. Address 0x7FF wraps to 0x000.
- Strobes while `busy` is high are discarded, with no effect.
- Horizontal counter `hcnt` (11 bits):
  - Loads 0 on the edge where `_hsyncin` is sampled low after having been sampled high.
  - Otherwise increments, saturating at 2047.
- Vertical counter `vcnt` (10 bits):
  - Loads 0 on a `_vsyncin` falling edge (same sampling rule as `hcnt`).
  - Increments on each `_hsyncin` falling edge, saturating at 1023.
  - If both falling edges occur on the same cycle, vsync wins: `vcnt` = 0.
- `enable` <= pending_enable on each `_vsyncin` falling edge only, so the window never tears mid-frame.
- Window condition: `enable`, HSTART <= hcnt < HSTART+1024, and VSTART <= vcnt < VSTART+64.
  - dx = hcnt-HSTART, dy = vcnt-VSTART.
  - Column = dx[9:2], so each OSD pixel is 4 clk28m wide.
  - Row = dy[5:3], bit = dy[2:0].
- `osdpixel` = byte[bit] when in window, else 0.
- Host writes and raster reads run concurrently. When a write and a read hit the same address in the same cycle, the read returns the old byte.

## Timing
- Reset values: `osdblank`=0, `osdpixel`=0, `busy`=0, enable=0, pending_enable=0, write address=0, `hcnt`=2047, `vcnt`=1023. Bitmap contents are not reset.
- Raster pipeline latency is 2 cycles (RAM read, output register). `osdblank`/`osdpixel` change exactly 2 cycles after the `hcnt` value that selects them.
- The first window pixel appears HSTART+3 rising edges after the edge that first samples `_hsyncin` low.
- Command and data writes take effect on the cycle after the strobe.
- A `busy` rise is visible on the cycle after the clear strobe.
- `_reset` asserted mid-clear: `busy` drops immediately and the clear is abandoned. Bitmap contents are then undefined until the next clear.
- Missing syncs: the counters saturate, so the window stays off.

## Structure
- Package `osd_pkg` holds:
  - OSD_COLS=256, OSD_ROWS=8, OSD_LINES=64, PIX_CLKS=4, BUF_AW=11.
  - Opcode constants: CMD_ADDR, CMD_EN, CMD_CLR.
- Sub-module `osd_ram`: 2048x8 simple dual-port RAM. One write port and one read port with registered output, no reset.
- The top level holds the sync edge detectors, counters, command decoder, clear sequencer and output register.

## Test plan
- Reset, then enable command, then one vsync: `osdblank`=0 before the vsync. After it, `osdblank` first rises at line VSTART, HSTART+3 edges after the hsync sample. It stays high 1024 cycles and is high for 64 lines.
- Address row 2, write 0x01 then 0xFF:
  - Line VSTART+16: pixel high for dx 0-7.
  - Lines VSTART+17 to +23: pixel high only for dx 4-7.
- Write 2049 data bytes from address 0: the last byte overwrites address 0.
- Clear command: `busy` is high for exactly 2048 cycles. A data strobe at cycle 100 of the clear is dropped. All pixels read 0 afterwards.
- Enable-off command mid-frame: the window persists to the end of the frame and is absent after the next vsync.
- `_reset` pulse during a clear and during an active window: `busy`, `osdblank` and `osdpixel` all go 0 asynchronously, and the window stays off.
